// File: rtl/mem_access_unit.sv
// MEM stage access unit: issues one data-memory request per load/store, freezes the
// pipeline until ack or timeout, and owns the MEM/WB pipeline register.
module mem_access_unit #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] mem_aluc,
  input  logic [31:0] mem_rd2,
  input  logic        mem_dram_we,
  input  logic        mem_dram_re,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_ext,
  input  logic [31:0] mem_pc,
  input  logic        mem_rf_we,
  input  logic [2:0]  mem_wd_sel,
  input  logic [4:0]  mem_wr,
  input  logic        mem_have_inst,
  output logic        dram_req,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata,
  output logic        mem_stall_o,
  output logic        err_o,
  output logic [31:0] wb_aluc,
  output logic [31:0] wb_pc4,
  output logic [31:0] wb_ext,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_rdata,
  output logic        wb_rf_we,
  output logic [2:0]  wb_wd_sel,
  output logic [4:0]  wb_wr,
  output logic        wb_have_inst
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          access, timeout_hit, done;

  assign access      = mem_have_inst & (mem_dram_we | mem_dram_re);
  assign timeout_hit = (state_q == S_WAIT) & (cnt_q == CNT_LAST) & ~dram_ack;
  assign done        = (state_q == S_WAIT) & (dram_ack | timeout_hit);

  always_comb begin
    state_d     = state_q;
    mem_stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_stall_o = access;
        if (access) state_d = S_WAIT;
      end
      S_WAIT: begin
        mem_stall_o = ~dram_ack & ~timeout_hit;
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dram_req   <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && access) begin
        // Request is captured once; the frozen pipeline keeps it stable anyway.
        dram_req   <= 1'b1;
        dram_we    <= mem_dram_we;
        dram_addr  <= mem_aluc;
        dram_wdata <= mem_rd2;
        cnt_q      <= '0;
      end else if (done) begin
        dram_req <= 1'b0;
      end else if (state_q == S_WAIT && cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) err_o <= 1'b1;
    end
  end

  // Only a finished WAIT can coincide with stall low, so a load here is ack or timeout.
  logic [31:0] rdata_sel;
  always_comb begin
    rdata_sel = '0;
    if (state_q == S_WAIT && !dram_we) rdata_sel = dram_ack ? dram_rdata : ERR_DATA;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_aluc      <= '0;
      wb_pc4       <= '0;
      wb_ext       <= '0;
      wb_pc        <= '0;
      wb_rdata     <= '0;
      wb_rf_we     <= 1'b0;
      wb_wd_sel    <= '0;
      wb_wr        <= '0;
      wb_have_inst <= 1'b0;
    end else if (mem_stall_o) begin
      wb_rf_we     <= 1'b0;
      wb_have_inst <= 1'b0;
    end else begin
      wb_aluc      <= mem_aluc;
      wb_pc4       <= mem_pc4;
      wb_ext       <= mem_ext;
      wb_pc        <= mem_pc;
      wb_rdata     <= rdata_sel;
      wb_rf_we     <= mem_rf_we;
      wb_wd_sel    <= mem_wd_sel;
      wb_wr        <= mem_wr;
      wb_have_inst <= mem_have_inst;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, timeout, ack-at-limit,
// reset mid-access and back-to-back traffic.
module tb_mem_access_unit;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic [31:0] mem_aluc = '0, mem_rd2 = '0, mem_pc4 = '0, mem_ext = '0, mem_pc = '0;
  logic        mem_dram_we = 1'b0, mem_dram_re = 1'b0, mem_rf_we = 1'b0, mem_have_inst = 1'b0;
  logic [2:0]  mem_wd_sel = '0;
  logic [4:0]  mem_wr = '0;
  logic        dram_ack = 1'b0;
  logic [31:0] dram_rdata = '0;
  logic        dram_req, dram_we, mem_stall_o, err_o, wb_rf_we, wb_have_inst;
  logic [31:0] dram_addr, dram_wdata, wb_aluc, wb_pc4, wb_ext, wb_pc, wb_rdata;
  logic [2:0]  wb_wd_sel;
  logic [4:0]  wb_wr;

  int checks = 0, errors = 0;

  mem_access_unit #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .mem_aluc(mem_aluc), .mem_rd2(mem_rd2),
    .mem_dram_we(mem_dram_we), .mem_dram_re(mem_dram_re), .mem_pc4(mem_pc4),
    .mem_ext(mem_ext), .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_wd_sel(mem_wd_sel),
    .mem_wr(mem_wr), .mem_have_inst(mem_have_inst), .dram_req(dram_req), .dram_we(dram_we),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ack(dram_ack),
    .dram_rdata(dram_rdata), .mem_stall_o(mem_stall_o), .err_o(err_o), .wb_aluc(wb_aluc),
    .wb_pc4(wb_pc4), .wb_ext(wb_ext), .wb_pc(wb_pc), .wb_rdata(wb_rdata),
    .wb_rf_we(wb_rf_we), .wb_wd_sel(wb_wd_sel), .wb_wr(wb_wr), .wb_have_inst(wb_have_inst)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic have, input logic we, input logic re,
                       input logic [31:0] aluc, input logic [31:0] rd2);
    mem_have_inst = have;
    mem_dram_we   = we;
    mem_dram_re   = re;
    mem_aluc      = aluc;
    mem_rd2       = rd2;
    mem_pc        = aluc ^ 32'h1000;
    mem_pc4       = (aluc ^ 32'h1000) + 32'd4;
    mem_ext       = aluc + 32'd7;
    mem_rf_we     = have & ~we;
    mem_wd_sel    = 3'd2;
    mem_wr        = aluc[4:0] | 5'd1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dram_req !== 1'b0 || dram_we !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: req=%b we=%b err=%b expected 0 0 0", dram_req, dram_we, err_o); end
    checks++; if (dram_addr !== 32'h0 || dram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: addr=%h wdata=%h expected 0 0", dram_addr, dram_wdata); end
    checks++; if ({wb_aluc, wb_pc4, wb_ext, wb_pc, wb_rdata} !== '0 ||
                  {wb_rf_we, wb_wd_sel, wb_wr, wb_have_inst} !== '0) begin
      errors++; $display("FAIL reset_wb: aluc=%h rdata=%h have=%b expected all 0", wb_aluc, wb_rdata, wb_have_inst); end
    rst_n_i = 1'b1;
  endtask

  task automatic test_load_ack;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    #1 checks++; if (mem_stall_o !== 1'b1) begin
      errors++; $display("FAIL load_idle_stall: got %b expected 1", mem_stall_o); end
    @(negedge clk_i);
    checks++; if (dram_req !== 1'b1 || dram_we !== 1'b0 || dram_addr !== 32'h100) begin
      errors++; $display("FAIL load_req: req=%b we=%b addr=%h expected 1 0 00000100", dram_req, dram_we, dram_addr); end
    dram_ack = 1'b1; dram_rdata = 32'h12345678;
    #1 checks++; if (mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL load_ack_stall: got %b expected 0", mem_stall_o); end
    @(negedge clk_i);
    dram_ack = 1'b0;
    checks++; if (wb_rdata !== 32'h12345678 || wb_have_inst !== 1'b1 || dram_req !== 1'b0) begin
      errors++; $display("FAIL load_wb: rdata=%h have=%b req=%b expected 12345678 1 0", wb_rdata, wb_have_inst, dram_req); end
    checks++; if (wb_aluc !== 32'h100 || wb_pc4 !== 32'h1104 || wb_ext !== 32'h107 || wb_wr !== 5'd1 || wb_rf_we !== 1'b1) begin
      errors++; $display("FAIL load_pass: aluc=%h pc4=%h ext=%h wr=%0d rf_we=%b expected 100 1104 107 1 1",
                         wb_aluc, wb_pc4, wb_ext, wb_wr, wb_rf_we); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_store;
    int stalls = 0;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'hA5A5A5A5);
    #1 if (mem_stall_o) stalls++;
    @(negedge clk_i);
    mem_rd2 = 32'h0; // register must not follow the input once WAIT is entered
    for (int i = 0; i < 3; i++) begin
      #1 if (mem_stall_o) stalls++;
      checks++; if (dram_req !== 1'b1 || dram_we !== 1'b1 || dram_addr !== 32'h200 || dram_wdata !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h expected 1 1 00000200 a5a5a5a5",
                           i, dram_req, dram_we, dram_addr, dram_wdata); end
      @(negedge clk_i);
    end
    dram_ack = 1'b1; dram_rdata = 32'h55555555;
    #1 if (mem_stall_o) stalls++;
    checks++; if (stalls !== 4) begin
      errors++; $display("FAIL store_stalls: got %0d expected 4", stalls); end
    @(negedge clk_i);
    dram_ack = 1'b0;
    checks++; if (wb_rdata !== 32'h0 || wb_aluc !== 32'h200 || wb_have_inst !== 1'b1 || dram_req !== 1'b0) begin
      errors++; $display("FAIL store_wb: rdata=%h aluc=%h have=%b req=%b expected 0 200 1 0", wb_rdata, wb_aluc, wb_have_inst, dram_req); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_timeout;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h0);
    @(negedge clk_i);
    for (int i = 0; i < 16; i++) begin
      #1 checks++; if (dram_req !== 1'b1 || mem_stall_o !== (i != 15) || err_o !== 1'b0) begin
        errors++; $display("FAIL timeout_wait[%0d]: req=%b stall=%b err=%b expected 1 %b 0", i, dram_req, mem_stall_o, err_o, i != 15); end
      @(negedge clk_i);
    end
    checks++; if (dram_req !== 1'b0 || err_o !== 1'b1 || wb_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL timeout_end: req=%b err=%b rdata=%h expected 0 1 deadbeef", dram_req, err_o, wb_rdata); end
    // A successful access afterwards must not clear the sticky flag.
    drive(1'b1, 1'b0, 1'b1, 32'h304, 32'h0);
    @(negedge clk_i);
    dram_ack = 1'b1; dram_rdata = 32'h0BADF00D;
    @(negedge clk_i);
    dram_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (err_o !== 1'b1 || wb_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL timeout_sticky: err=%b rdata=%h expected 1 0badf00d", err_o, wb_rdata); end
  endtask

  task automatic test_ack_at_limit;
    test_reset;
    drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h0);
    @(negedge clk_i);
    for (int i = 0; i < 15; i++) @(negedge clk_i);
    dram_ack = 1'b1; dram_rdata = 32'hCAFEF00D;
    #1 checks++; if (mem_stall_o !== 1'b0 || dram_req !== 1'b1) begin
      errors++; $display("FAIL limit_ack_cycle: stall=%b req=%b expected 0 1", mem_stall_o, dram_req); end
    @(negedge clk_i);
    dram_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (err_o !== 1'b0 || wb_rdata !== 32'hCAFEF00D || dram_req !== 1'b0) begin
      errors++; $display("FAIL limit_ack: err=%b rdata=%h req=%b expected 0 cafef00d 0", err_o, wb_rdata, dram_req); end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 1'b1, 32'h500, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (dram_req !== 1'b1) begin
      errors++; $display("FAIL rstwait_pre: req=%b expected 1", dram_req); end
    rst_n_i = 1'b0;
    #1 checks++; if (dram_req !== 1'b0 || wb_aluc !== 32'h0 || wb_rdata !== 32'h0 || wb_have_inst !== 1'b0 || wb_pc4 !== 32'h0) begin
      errors++; $display("FAIL rstwait_async: req=%b aluc=%h rdata=%h have=%b expected 0 0 0 0", dram_req, wb_aluc, wb_rdata, wb_have_inst); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    dram_ack = 1'b1; dram_rdata = 32'h77777777;
    #1 checks++; if (mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL stray_ack_stall: got %b expected 0", mem_stall_o); end
    @(negedge clk_i);
    dram_ack = 1'b0;
    @(negedge clk_i);
    checks++; if (dram_req !== 1'b0 || wb_rdata !== 32'h0 || err_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL stray_ack: req=%b rdata=%h err=%b stall=%b expected 0 0 0 0", dram_req, wb_rdata, err_o, mem_stall_o); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 1'b1, 32'h600, 32'h0);
    #1 checks++; if (mem_stall_o !== 1'b1) begin
      errors++; $display("FAIL b2b_a_stall: got %b expected 1", mem_stall_o); end
    @(negedge clk_i);
    dram_ack = 1'b1; dram_rdata = 32'h11111111;
    @(negedge clk_i);
    dram_ack = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h604, 32'h0);
    #1 checks++; if (mem_stall_o !== 1'b1 || dram_req !== 1'b0 || wb_rdata !== 32'h11111111) begin
      errors++; $display("FAIL b2b_b_start: stall=%b req=%b rdata=%h expected 1 0 11111111", mem_stall_o, dram_req, wb_rdata); end
    @(negedge clk_i);
    checks++; if (dram_req !== 1'b1 || dram_addr !== 32'h604 || wb_have_inst !== 1'b0 || wb_rf_we !== 1'b0 || wb_rdata !== 32'h11111111) begin
      errors++; $display("FAIL b2b_bubble: req=%b addr=%h have=%b rf_we=%b rdata=%h expected 1 604 0 0 11111111",
                         dram_req, dram_addr, wb_have_inst, wb_rf_we, wb_rdata); end
    dram_ack = 1'b1; dram_rdata = 32'h22222222;
    #1 checks++; if (mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL b2b_b_ack: stall=%b expected 0", mem_stall_o); end
    @(negedge clk_i);
    dram_ack = 1'b0;
    checks++; if (wb_rdata !== 32'h22222222 || wb_aluc !== 32'h604 || wb_have_inst !== 1'b1) begin
      errors++; $display("FAIL b2b_b_wb: rdata=%h aluc=%h have=%b expected 22222222 604 1", wb_rdata, wb_aluc, wb_have_inst); end
    drive(1'b1, 1'b0, 1'b0, 32'h0000ABCD, 32'h0);
    #1 checks++; if (mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL alu_stall: got %b expected 0", mem_stall_o); end
    @(negedge clk_i);
    checks++; if (wb_rdata !== 32'h0 || wb_aluc !== 32'h0000ABCD || wb_have_inst !== 1'b1 || wb_rf_we !== 1'b1 || dram_req !== 1'b0) begin
      errors++; $display("FAIL alu_wb: rdata=%h aluc=%h have=%b rf_we=%b req=%b expected 0 abcd 1 1 0",
                         wb_rdata, wb_aluc, wb_have_inst, wb_rf_we, dram_req); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_load_ack;
    test_store;
    test_timeout;
    test_ack_at_limit;
    test_reset_mid_wait;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
